// File: rtl/conv2d_mac_scheduler.sv
// Sequential single-MAC 2-D convolution engine: walks (b, oc, oh, ow, ic, kh, kw),
// reads activations/weights/bias from 1-cycle sync-read memories and writes one output per pixel.
module conv2d_mac_scheduler #(
  parameter int unsigned BATCH_SIZE   = 1,
  parameter int unsigned IN_CHANNELS  = 2,
  parameter int unsigned OUT_CHANNELS = 1,
  parameter int unsigned IN_HEIGHT    = 4,
  parameter int unsigned IN_WIDTH     = 4,
  parameter int unsigned KERNEL_SIZE  = 2,
  parameter int unsigned STRIDE       = 2,
  parameter int unsigned PADDING      = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  in_rd_en,
  output logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_rdata,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_rdata,
  output logic                  b_rd_en,
  output logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  out_wr_en,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_wdata
);

  localparam int BN   = int'(BATCH_SIZE);
  localparam int IC   = int'(IN_CHANNELS);
  localparam int OC   = int'(OUT_CHANNELS);
  localparam int IH   = int'(IN_HEIGHT);
  localparam int IW   = int'(IN_WIDTH);
  localparam int K    = int'(KERNEL_SIZE);
  localparam int STR  = int'(STRIDE);
  localparam int PAD  = int'(PADDING);
  localparam int OH   = (IH + 2 * PAD - K) / STR + 1;
  localparam int OW   = (IW + 2 * PAD - K) / STR + 1;
  localparam int TAPS = IC * K * K;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_LAST, S_WRITE, S_DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   b_q, oc_q, oh_q, ow_q, ic_q, kh_q, kw_q;
  logic [CW-1:0]   b_nx, oc_nx, oh_nx, ow_nx, ic_nx, kh_nx, kw_nx;
  logic [DATA_WIDTH-1:0] acc, acc_nx, prod;
  logic [ADDR_WIDTH-1:0] in_addr_nx, w_addr_nx, out_addr_nx;
  logic            pad_q, tap_ok_nx, last_tap, last_pix, first_tap;
  int              ih, iw;

  assign last_tap  = (ic_q == CW'(IC - 1)) && (kh_q == CW'(K - 1)) && (kw_q == CW'(K - 1));
  assign first_tap = (ic_q == '0) && (kh_q == '0) && (kw_q == '0);
  assign last_pix  = (ow_q == CW'(OW - 1)) && (oh_q == CW'(OH - 1)) &&
                     (oc_q == CW'(OC - 1)) && (b_q == CW'(BN - 1));

  // Next state and loop-nest counters
  always_comb begin
    state_nx = state;
    b_nx  = b_q;  oc_nx = oc_q; oh_nx = oh_q; ow_nx = ow_q;
    ic_nx = ic_q; kh_nx = kh_q; kw_nx = kw_q;
    case (state)
      S_IDLE:  if (start) state_nx = S_BIAS;
      S_BIAS:  state_nx = S_MAC;
      S_MAC: begin
        if (last_tap) begin
          state_nx = S_LAST;
          ic_nx = '0; kh_nx = '0; kw_nx = '0;
        end else if (kw_q != CW'(K - 1)) begin
          kw_nx = kw_q + CW'(1);
        end else begin
          kw_nx = '0;
          if (kh_q != CW'(K - 1)) kh_nx = kh_q + CW'(1);
          else begin
            kh_nx = '0;
            ic_nx = ic_q + CW'(1);
          end
        end
      end
      S_LAST:  state_nx = S_WRITE;
      S_WRITE: begin
        if (last_pix) begin
          state_nx = S_DONE;
          b_nx = '0; oc_nx = '0; oh_nx = '0; ow_nx = '0;
        end else begin
          state_nx = S_BIAS;
          if (ow_q != CW'(OW - 1)) ow_nx = ow_q + CW'(1);
          else begin
            ow_nx = '0;
            if (oh_q != CW'(OH - 1)) oh_nx = oh_q + CW'(1);
            else begin
              oh_nx = '0;
              if (oc_q != CW'(OC - 1)) oc_nx = oc_q + CW'(1);
              else begin
                oc_nx = '0;
                b_nx  = b_q + CW'(1);
              end
            end
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Tap addressing for the next cycle, and accumulator update for this one
  always_comb begin
    ih = int'(oh_nx) * STR + int'(kh_nx) - PAD;
    iw = int'(ow_nx) * STR + int'(kw_nx) - PAD;
    tap_ok_nx  = (state_nx == S_MAC) && (ih >= 0) && (ih < IH) && (iw >= 0) && (iw < IW);
    in_addr_nx = '0;
    w_addr_nx  = '0;
    if (tap_ok_nx) begin
      in_addr_nx = ADDR_WIDTH'(int'(b_nx) * IC * IH * IW + int'(ic_nx) * IH * IW + ih * IW + iw);
      w_addr_nx  = ADDR_WIDTH'(int'(oc_nx) * TAPS + int'(ic_nx) * K * K + int'(kh_nx) * K + int'(kw_nx));
    end
    out_addr_nx = ADDR_WIDTH'(int'(b_q) * OC * OH * OW + int'(oc_q) * OH * OW + int'(oh_q) * OW + int'(ow_q));
    prod   = pad_q ? '0 : in_rdata * w_rdata;
    acc_nx = acc;
    case (state)
      S_MAC:   acc_nx = first_tap ? b_rdata : acc + prod;
      S_LAST:  acc_nx = acc + prod;
      default: acc_nx = acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      b_q  <= '0; oc_q <= '0; oh_q <= '0; ow_q <= '0;
      ic_q <= '0; kh_q <= '0; kw_q <= '0;
      acc  <= '0; pad_q <= 1'b0;
      busy <= 1'b0; done <= 1'b0;
      in_rd_en <= 1'b0; in_addr <= '0;
      w_rd_en  <= 1'b0; w_addr  <= '0;
      b_rd_en  <= 1'b0; b_addr  <= '0;
      out_wr_en <= 1'b0; out_addr <= '0; out_wdata <= '0;
    end else begin
      state <= state_nx;
      b_q  <= b_nx;  oc_q <= oc_nx; oh_q <= oh_nx; ow_q <= ow_nx;
      ic_q <= ic_nx; kh_q <= kh_nx; kw_q <= kw_nx;
      acc  <= acc_nx;
      // A MAC cycle without a read is a padded tap; its product arrives next cycle
      pad_q <= (state == S_MAC) && !in_rd_en;
      busy <= (state_nx == S_BIAS) || (state_nx == S_MAC) ||
              (state_nx == S_LAST) || (state_nx == S_WRITE);
      done <= (state_nx == S_DONE);
      in_rd_en <= tap_ok_nx; in_addr <= in_addr_nx;
      w_rd_en  <= tap_ok_nx; w_addr  <= w_addr_nx;
      b_rd_en  <= (state_nx == S_BIAS);
      b_addr   <= (state_nx == S_BIAS) ? ADDR_WIDTH'(oc_nx) : '0;
      out_wr_en <= (state_nx == S_WRITE);
      out_addr  <= (state_nx == S_WRITE) ? out_addr_nx : '0;
      out_wdata <= (state_nx == S_WRITE) ? acc_nx : '0;
    end
  end

endmodule

// File: tb/tb_conv2d_mac_scheduler.sv
// Directed bench for conv2d_mac_scheduler: three configurations (default, padded 3x3, 2 batch x 2 oc)
// with sync-read memory models, a write log per instance and a table of expected writes.
module tb_conv2d_mac_scheduler;

  typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int test; int inst; int idx; logic [15:0] addr; logic [31:0] data; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  logic        busy_a, done_a, in_rd_en_a, w_rd_en_a, b_rd_en_a, out_wr_en_a;
  logic [15:0] in_addr_a, w_addr_a, b_addr_a, out_addr_a;
  logic [31:0] in_rdata_a, w_rdata_a, b_rdata_a, out_wdata_a;
  logic        busy_b, done_b, in_rd_en_b, w_rd_en_b, b_rd_en_b, out_wr_en_b;
  logic [15:0] in_addr_b, w_addr_b, b_addr_b, out_addr_b;
  logic [31:0] in_rdata_b, w_rdata_b, b_rdata_b, out_wdata_b;
  logic        busy_c, done_c, in_rd_en_c, w_rd_en_c, b_rd_en_c, out_wr_en_c;
  logic [15:0] in_addr_c, w_addr_c, b_addr_c, out_addr_c;
  logic [31:0] in_rdata_c, w_rdata_c, b_rdata_c, out_wdata_c;

  logic [31:0] mem_in_a [64], mem_w_a [64], mem_b_a [64];
  logic [31:0] mem_in_b [64], mem_w_b [64], mem_b_b [64];
  logic [31:0] mem_in_c [64], mem_w_c [64], mem_b_c [64];

  wr_t         wr_a [$], wr_b [$], wr_c [$];
  logic [15:0] baddr_c [$];
  int done_cnt_a = 0, rd_cnt_b = 0, wrd_cnt_b = 0;
  int n_cmp = 0, n_bad = 0;
  vec_t vecs [$];

  always #5 clk = ~clk;

  conv2d_mac_scheduler dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .in_rd_en(in_rd_en_a), .in_addr(in_addr_a), .in_rdata(in_rdata_a),
    .w_rd_en(w_rd_en_a), .w_addr(w_addr_a), .w_rdata(w_rdata_a),
    .b_rd_en(b_rd_en_a), .b_addr(b_addr_a), .b_rdata(b_rdata_a),
    .out_wr_en(out_wr_en_a), .out_addr(out_addr_a), .out_wdata(out_wdata_a));

  conv2d_mac_scheduler #(.IN_CHANNELS(1), .IN_HEIGHT(2), .IN_WIDTH(2), .KERNEL_SIZE(3),
                         .STRIDE(1), .PADDING(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .in_rd_en(in_rd_en_b), .in_addr(in_addr_b), .in_rdata(in_rdata_b),
    .w_rd_en(w_rd_en_b), .w_addr(w_addr_b), .w_rdata(w_rdata_b),
    .b_rd_en(b_rd_en_b), .b_addr(b_addr_b), .b_rdata(b_rdata_b),
    .out_wr_en(out_wr_en_b), .out_addr(out_addr_b), .out_wdata(out_wdata_b));

  conv2d_mac_scheduler #(.BATCH_SIZE(2), .OUT_CHANNELS(2)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
    .in_rd_en(in_rd_en_c), .in_addr(in_addr_c), .in_rdata(in_rdata_c),
    .w_rd_en(w_rd_en_c), .w_addr(w_addr_c), .w_rdata(w_rdata_c),
    .b_rd_en(b_rd_en_c), .b_addr(b_addr_c), .b_rdata(b_rdata_c),
    .out_wr_en(out_wr_en_c), .out_addr(out_addr_c), .out_wdata(out_wdata_c));

  // One-cycle-latency memories
  always @(posedge clk) begin
    if (in_rd_en_a) in_rdata_a <= mem_in_a[in_addr_a[5:0]];
    if (w_rd_en_a)  w_rdata_a  <= mem_w_a[w_addr_a[5:0]];
    if (b_rd_en_a)  b_rdata_a  <= mem_b_a[b_addr_a[5:0]];
    if (in_rd_en_b) in_rdata_b <= mem_in_b[in_addr_b[5:0]];
    if (w_rd_en_b)  w_rdata_b  <= mem_w_b[w_addr_b[5:0]];
    if (b_rd_en_b)  b_rdata_b  <= mem_b_b[b_addr_b[5:0]];
    if (in_rd_en_c) in_rdata_c <= mem_in_c[in_addr_c[5:0]];
    if (w_rd_en_c)  w_rdata_c  <= mem_w_c[w_addr_c[5:0]];
    if (b_rd_en_c)  b_rdata_c  <= mem_b_c[b_addr_c[5:0]];
  end

  always @(negedge clk) begin
    if (out_wr_en_a) wr_a.push_back({out_addr_a, out_wdata_a});
    if (done_a)      done_cnt_a++;
    if (out_wr_en_b) wr_b.push_back({out_addr_b, out_wdata_b});
    if (in_rd_en_b)  rd_cnt_b++;
    if (w_rd_en_b)   wrd_cnt_b++;
    if (out_wr_en_c) wr_c.push_back({out_addr_c, out_wdata_c});
    if (b_rd_en_c)   baddr_c.push_back(b_addr_c);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic done_of(input int inst);
    case (inst)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic pulse_start(input int inst);
    tick();
    case (inst) 0: start_a = 1'b1; 1: start_b = 1'b1; default: start_c = 1'b1; endcase
    tick();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  // Returns cycle number (1 = first cycle after the sampling edge) at which done is seen
  task automatic wait_done(input int inst, input int max, output int cyc);
    cyc = 1;
    while (!done_of(inst) && cyc < max) begin
      tick();
      cyc++;
    end
    if (!done_of(inst)) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout inst %0d: no done after %0d cycles", inst, cyc);
    end
  endtask

  function automatic void add_vec(input int test, input int inst, input int idx,
                                  input logic [15:0] addr, input logic [31:0] data);
    vecs.push_back('{test, inst, idx, addr, data});
  endfunction

  task automatic check_table(input int test_id, input int offset);
    wr_t w;
    int  k;
    bit  have;
    foreach (vecs[i]) begin
      if (vecs[i].test == test_id) begin
        k = vecs[i].idx + offset;
        have = 1'b0;
        w = '0;
        case (vecs[i].inst)
          0:       if (k < wr_a.size()) begin w = wr_a[k]; have = 1'b1; end
          1:       if (k < wr_b.size()) begin w = wr_b[k]; have = 1'b1; end
          default: if (k < wr_c.size()) begin w = wr_c[k]; have = 1'b1; end
        endcase
        if (!have) begin
          n_cmp++; n_bad++;
          $display("FAIL t%0d write %0d missing: got none expected addr %0d", test_id, k, vecs[i].addr);
        end else begin
          check($sformatf("t%0d addr[%0d]", test_id, k), 32'(w.addr), 32'(vecs[i].addr));
          check($sformatf("t%0d data[%0d]", test_id, k), w.data, vecs[i].data);
        end
      end
    end
  endtask

  task automatic load_a_t1();
    for (int i = 0; i < 64; i++) begin
      mem_in_a[i] = (i < 16) ? 32'(i) : 32'd1;
      mem_w_a[i]  = 32'd1;
      mem_b_a[i]  = 32'd0;
    end
  endtask

  task automatic clear_a();
    wr_a.delete();
    done_cnt_a = 0;
  endtask

  function automatic logic [31:0] ref_c(input int bb, input int oc, input int oh, input int ow);
    logic [31:0] acc;
    acc = mem_b_c[oc];
    for (int ic = 0; ic < 2; ic++)
      for (int kh = 0; kh < 2; kh++)
        for (int kw = 0; kw < 2; kw++)
          acc = acc + mem_in_c[bb * 32 + ic * 16 + (oh * 2 + kh) * 4 + ow * 2 + kw] *
                      mem_w_c[oc * 8 + ic * 4 + kh * 2 + kw];
    return acc;
  endfunction

  initial begin
    int cyc;
    int cnt;

    add_vec(1, 0, 0, 16'd0, 32'd14);
    add_vec(1, 0, 1, 16'd1, 32'd22);
    add_vec(1, 0, 2, 16'd2, 32'd46);
    add_vec(1, 0, 3, 16'd3, 32'd54);
    for (int i = 0; i < 4; i++) add_vec(2, 1, i, 16'(i), 32'd9);
    for (int i = 0; i < 4; i++) add_vec(3, 0, i, 16'(i), 32'hFFFF_FFED);
    for (int i = 0; i < 4; i++) add_vec(4, 0, i, 16'(i), 32'hFFFF_FFFE);

    // Reset state
    tick();
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    check("rst in_rd_en", 32'(in_rd_en_a), 32'd0);
    check("rst b_rd_en", 32'(b_rd_en_a), 32'd0);
    check("rst out_wr_en", 32'(out_wr_en_a), 32'd0);
    check("rst out_addr", 32'(out_addr_a), 32'd0);
    check("rst out_wdata", out_wdata_a, 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: basic run and latency
    load_a_t1();
    clear_a();
    pulse_start(0);
    check("t1 busy cycle1", 32'(busy_a), 32'd1);
    check("t1 b_rd_en cycle1", 32'(b_rd_en_a), 32'd1);
    wait_done(0, 200, cyc);
    check("t1 done cycle", 32'(cyc), 32'd45);
    check("t1 busy at done", 32'(busy_a), 32'd0);
    check("t1 write count", 32'(wr_a.size()), 32'd4);
    check_table(1, 0);
    tick();
    check("t1 done count", 32'(done_cnt_a), 32'd1);

    // Test 3a: signed accumulate
    for (int i = 0; i < 64; i++) begin
      mem_in_a[i] = 32'd2;
      mem_w_a[i]  = 32'hFFFF_FFFF;
      mem_b_a[i]  = 32'hFFFF_FFFD;
    end
    clear_a();
    pulse_start(0);
    wait_done(0, 200, cyc);
    check_table(3, 0);

    // Test 3b: product truncation
    for (int i = 0; i < 64; i++) begin
      mem_in_a[i] = 32'h7FFF_FFFF;
      mem_w_a[i]  = (i == 0) ? 32'd2 : 32'd0;
      mem_b_a[i]  = 32'd0;
    end
    clear_a();
    pulse_start(0);
    wait_done(0, 200, cyc);
    check_table(4, 0);

    // Test 4: start held high across a whole run
    load_a_t1();
    tick();
    clear_a();
    start_a = 1'b1;
    tick();
    wait_done(0, 200, cyc);
    check("t4 writes first run", 32'(wr_a.size()), 32'd4);
    tick();
    check("t4 done count first", 32'(done_cnt_a), 32'd1);
    check("t4 idle busy", 32'(busy_a), 32'd0);
    tick();
    check("t4 restart busy", 32'(busy_a), 32'd1);
    start_a = 1'b0;
    wait_done(0, 200, cyc);
    tick();
    check("t4 writes total", 32'(wr_a.size()), 32'd8);
    check("t4 done count total", 32'(done_cnt_a), 32'd2);
    check_table(1, 0);
    check_table(1, 4);

    // Test 5: reset in the middle of pixel 2
    clear_a();
    pulse_start(0);
    cnt = 0;
    while (wr_a.size() < 2 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("t5 reached pixel 2", 32'(wr_a.size()), 32'd2);
    tick(); tick(); tick();
    check("t5 pre-rst in_rd_en", 32'(in_rd_en_a), 32'd1);
    check("t5 pre-rst in_addr", 32'(in_addr_a), 32'd9);
    check("t5 pre-rst w_addr", 32'(w_addr_a), 32'd1);
    rst = 1'b1;
    #1;
    check("t5 rst busy", 32'(busy_a), 32'd0);
    check("t5 rst in_rd_en", 32'(in_rd_en_a), 32'd0);
    check("t5 rst in_addr", 32'(in_addr_a), 32'd0);
    check("t5 rst w_rd_en", 32'(w_rd_en_a), 32'd0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("t5 no writes after rst", 32'(wr_a.size()), 32'd2);
    check("t5 no done after rst", 32'(done_cnt_a), 32'd0);
    clear_a();
    pulse_start(0);
    wait_done(0, 200, cyc);
    check("t5 rerun cycle", 32'(cyc), 32'd45);
    check_table(1, 0);

    // Test 2: padded 3x3 kernel, stride 1
    for (int i = 0; i < 64; i++) begin
      mem_in_b[i] = 32'd1;
      mem_w_b[i]  = 32'd1;
      mem_b_b[i]  = 32'd5;
    end
    rd_cnt_b = 0;
    wrd_cnt_b = 0;
    pulse_start(1);
    wait_done(1, 200, cyc);
    check("t2 write count", 32'(wr_b.size()), 32'd4);
    check_table(2, 0);
    check("t2 in reads", 32'(rd_cnt_b), 32'd16);
    check("t2 w reads", 32'(wrd_cnt_b), 32'd16);

    // Test 6: two batches, two output channels
    for (int i = 0; i < 64; i++) begin
      mem_in_c[i] = 32'(i - 20);
      mem_w_c[i]  = 32'((i % 3) - 1);
      mem_b_c[i]  = (i == 0) ? 32'd7 : 32'hFFFF_FF9C;
    end
    pulse_start(2);
    wait_done(2, 400, cyc);
    check("t6 write count", 32'(wr_c.size()), 32'd16);
    check("t6 bias read count", 32'(baddr_c.size()), 32'd16);
    for (int k = 0; k < 16; k++) begin
      if (k < wr_c.size()) begin
        check($sformatf("t6 addr[%0d]", k), 32'(wr_c[k].addr), 32'(k));
        check($sformatf("t6 data[%0d]", k), wr_c[k].data, ref_c(k / 8, (k / 4) % 2, (k / 2) % 2, k % 2));
      end
      if (k < baddr_c.size())
        check($sformatf("t6 b_addr[%0d]", k), 32'(baddr_c[k]), 32'((k / 4) % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
